ct_ciu_ebiuif_mc: RTL and testbench

Parametrised multi-channel EBIU interface between SNOOP_NUM snoop buffers (snb), the coherence transaction queue (ctcq) and the external bus interface unit (ebiu). It round-robin arbitrates snb read requests into a registered AR stage and routes R beats back by ID. It demultiplexes AC snoops by cache-line address bits or to ctcq for DVM sync/complete. It returns CR responses to ebiu in strict AC-acceptance order through an order FIFO, which was previously stubbed.

---
 rtl/ct_ciu_ebiuif_mc.sv | 224 ++++++++++++++++++++++
 tb/tb_ct_ciu_ebiuif_mc.sv | 570 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_ciu_ebiuif_mc.sv
// ct_ciu_ebiuif_mc: multi-channel EBIU interface for SNOOP_NUM snoop buffers and the ctcq.
//
// Ports:
//   forever_cpuclk / cpurst        clock, synchronous active-high reset
//   snbx_ebiuif_ar* / ebiuif_snbx_ar_grant / vb_*   per-snb AR requests, round-robin arbitrated
//   ebiuif_ebiu_ar* / ebiu_ebiuif_ar_grant            registered AR stage towards ebiu
//   ebiu_ebiuif_r* / ebiuif_snbx_rvalid / ebiuif_xx_r* / ebiuif_ebiu_r_grant
//                                  R beats routed to snb by rid[CH_W-1:0]
//   ebiu_ebiuif_ac* / ebiuif_{snbx,ctcq}_acvalid / ebiuif_xx_ac* / *_ac_grant
//                                  AC snoops routed by line address, or to ctcq for DVM
//   {snbx,ctcq}_ebiuif_cr* / ebiuif_{snbx,ctcq}_cr_grant / ebiuif_ebiu_cr* / ebiu_ebiuif_cr_grant
//                                  CR responses returned in AC-acceptance order
module ct_ciu_ebiuif_mc #(
  parameter int unsigned SNOOP_NUM = 2,
  parameter int unsigned ARWIDTH   = 69,
  parameter int unsigned PA_WIDTH  = 40,
  parameter int unsigned CR_DEPTH  = 4
) (
  input  logic                         forever_cpuclk,
  input  logic                         cpurst,
  // AR
  input  logic [SNOOP_NUM-1:0]         snbx_ebiuif_arvalid,
  input  logic [SNOOP_NUM*ARWIDTH-1:0] snbx_ebiuif_arbus,
  output logic [SNOOP_NUM-1:0]         ebiuif_snbx_ar_grant,
  input  logic                         vb_ebiuif_addr_depd,
  output logic [7:0]                   ebiuif_vb_index,
  output logic                         ebiuif_ebiu_arvalid,
  output logic [ARWIDTH-1:0]           ebiuif_ebiu_arbus,
  input  logic                         ebiu_ebiuif_ar_grant,
  // R
  input  logic                         ebiu_ebiuif_rvalid,
  input  logic [5:0]                   ebiu_ebiuif_rid,
  input  logic [127:0]                 ebiu_ebiuif_rdata,
  input  logic [3:0]                   ebiu_ebiuif_rresp,
  input  logic                         ebiu_ebiuif_rlast,
  output logic [SNOOP_NUM-1:0]         ebiuif_snbx_rvalid,
  output logic [127:0]                 ebiuif_xx_rdata,
  output logic [3:0]                   ebiuif_xx_rresp,
  output logic                         ebiuif_xx_rlast,
  output logic                         ebiuif_ebiu_r_grant,
  // AC
  input  logic                         ebiu_ebiuif_acvalid,
  input  logic [PA_WIDTH-1:0]          ebiu_ebiuif_acaddr,
  input  logic [3:0]                   ebiu_ebiuif_acsnoop,
  input  logic [4:0]                   ebiu_ebiuif_acid,
  input  logic [2:0]                   ebiu_ebiuif_acprot,
  output logic [SNOOP_NUM-1:0]         ebiuif_snbx_acvalid,
  output logic                         ebiuif_ctcq_acvalid,
  output logic [PA_WIDTH-1:0]          ebiuif_xx_acaddr,
  output logic [3:0]                   ebiuif_xx_acsnoop,
  output logic [4:0]                   ebiuif_xx_acid,
  output logic [2:0]                   ebiuif_xx_acprot,
  input  logic [SNOOP_NUM-1:0]         snbx_ebiuif_ac_grant,
  input  logic                         ctcq_ebiuif_ac_grant,
  output logic                         ebiuif_ebiu_ac_grant,
  // CR
  input  logic [SNOOP_NUM-1:0]         snbx_ebiuif_crvalid,
  input  logic [SNOOP_NUM*5-1:0]       snbx_ebiuif_crresp,
  input  logic                         ctcq_ebiuif_crvalid,
  input  logic [4:0]                   ctcq_ebiuif_crresp,
  output logic [SNOOP_NUM-1:0]         ebiuif_snbx_cr_grant,
  output logic                         ebiuif_ctcq_cr_grant,
  output logic                         ebiuif_ebiu_crvalid,
  output logic [4:0]                   ebiuif_ebiu_crresp,
  input  logic                         ebiu_ebiuif_cr_grant
);

  localparam int unsigned CH_W = $clog2(SNOOP_NUM);
  localparam int unsigned TW   = $clog2(SNOOP_NUM + 1);  // target code incl. ctcq
  localparam int unsigned PW   = $clog2(CR_DEPTH);
  localparam logic [SNOOP_NUM-1:0] OneLsb = SNOOP_NUM'(1);

  // State
  logic                rst_q;  // reset seen at the previous edge
  logic                ar_vld_q;
  logic [ARWIDTH-1:0]  ar_bus_q;
  logic [CH_W-1:0]     rr_ptr_q;
  logic [TW-1:0]       fifo_q [CR_DEPTH];
  logic [PW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [PW:0]         cnt_q;

  // Outputs stay quiet in reset and on the cycle right after it.
  logic blk;
  assign blk = cpurst | rst_q;

  // ---------------------------------------------------------------------------
  // AR round-robin arbiter and registered stage
  // ---------------------------------------------------------------------------
  logic               cand_vld;
  logic [CH_W-1:0]    win_idx;
  logic [ARWIDTH-1:0] cand_bus;
  logic               ar_load;

  always_comb begin
    cand_vld = 1'b0;
    win_idx  = '0;
    // Scan downwards so the channel closest to the pointer is assigned last and wins.
    for (int k = int'(SNOOP_NUM) - 1; k >= 0; k--) begin
      if (snbx_ebiuif_arvalid[rr_ptr_q + CH_W'(k)]) begin
        cand_vld = 1'b1;
        win_idx  = rr_ptr_q + CH_W'(k);
      end
    end
  end

  assign cand_bus        = cand_vld ? snbx_ebiuif_arbus[win_idx*ARWIDTH +: ARWIDTH] : '0;
  assign ebiuif_vb_index = cand_bus[13:6];

  // A grant from ebiu frees the register in the same cycle, giving bubble-free issue.
  assign ar_load = cand_vld & ~vb_ebiuif_addr_depd & (~ar_vld_q | ebiu_ebiuif_ar_grant) & ~blk;

  assign ebiuif_snbx_ar_grant = ar_load ? (OneLsb << win_idx) : '0;
  assign ebiuif_ebiu_arvalid  = ar_vld_q & ~blk;
  assign ebiuif_ebiu_arbus    = ar_bus_q;

  // ---------------------------------------------------------------------------
  // R routing
  // ---------------------------------------------------------------------------
  logic r_ok;
  assign r_ok = ebiu_ebiuif_rvalid & ~blk;

  always_comb begin
    ebiuif_snbx_rvalid = '0;
    for (int i = 0; i < int'(SNOOP_NUM); i++) begin
      ebiuif_snbx_rvalid[i] = r_ok & (ebiu_ebiuif_rid[CH_W-1:0] == CH_W'(i));
    end
  end

  assign ebiuif_ebiu_r_grant = r_ok;
  assign ebiuif_xx_rdata     = ebiu_ebiuif_rdata;
  assign ebiuif_xx_rresp     = ebiu_ebiuif_rresp;
  assign ebiuif_xx_rlast     = ebiu_ebiuif_rlast;

  // ---------------------------------------------------------------------------
  // AC demux
  // ---------------------------------------------------------------------------
  logic            ac_dvm;
  logic [CH_W-1:0] ac_ch;
  logic [TW-1:0]   ac_tgt;
  logic            fifo_full, fifo_empty;
  logic            ac_ok;
  logic            push, pop;

  assign ac_dvm     = (ebiu_ebiuif_acsnoop[3:1] == 3'b111);
  assign ac_ch      = ebiu_ebiuif_acaddr[6 +: CH_W];
  assign ac_tgt     = ac_dvm ? TW'(SNOOP_NUM) : TW'(ac_ch);
  // Full comes from the registered count; a same-cycle pop does not unblock AC.
  assign fifo_full  = (cnt_q == (PW+1)'(CR_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign ac_ok      = ebiu_ebiuif_acvalid & ~fifo_full & ~blk;

  assign ebiuif_snbx_acvalid  = (ac_ok & ~ac_dvm) ? (OneLsb << ac_ch) : '0;
  assign ebiuif_ctcq_acvalid  = ac_ok & ac_dvm;
  assign ebiuif_ebiu_ac_grant = ac_ok & (ac_dvm ? ctcq_ebiuif_ac_grant
                                                : snbx_ebiuif_ac_grant[ac_ch]);
  assign push                 = ebiuif_ebiu_ac_grant;

  assign ebiuif_xx_acaddr  = ebiu_ebiuif_acaddr;
  assign ebiuif_xx_acsnoop = ebiu_ebiuif_acsnoop;
  assign ebiuif_xx_acid    = ebiu_ebiuif_acid;
  assign ebiuif_xx_acprot  = ebiu_ebiuif_acprot;

  // ---------------------------------------------------------------------------
  // CR ordering: the FIFO head picks the only source allowed to respond.
  // ---------------------------------------------------------------------------
  logic [TW-1:0]   head;
  logic [CH_W-1:0] head_ch;

  assign head    = fifo_q[rd_ptr_q];
  assign head_ch = head[CH_W-1:0];

  always_comb begin
    ebiuif_ebiu_crvalid  = 1'b0;
    ebiuif_ebiu_crresp   = 5'd0;
    ebiuif_snbx_cr_grant = '0;
    ebiuif_ctcq_cr_grant = 1'b0;
    if (~fifo_empty & ~blk) begin
      if (head == TW'(SNOOP_NUM)) begin
        ebiuif_ebiu_crvalid  = ctcq_ebiuif_crvalid;
        ebiuif_ebiu_crresp   = ctcq_ebiuif_crresp;
        ebiuif_ctcq_cr_grant = ebiu_ebiuif_cr_grant;
      end else begin
        ebiuif_ebiu_crvalid           = snbx_ebiuif_crvalid[head_ch];
        ebiuif_ebiu_crresp            = snbx_ebiuif_crresp[head_ch*5 +: 5];
        ebiuif_snbx_cr_grant[head_ch] = ebiu_ebiuif_cr_grant;
      end
    end
  end

  assign pop = ebiu_ebiuif_cr_grant & ebiuif_ebiu_crvalid;

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      rst_q    <= 1'b1;
      ar_vld_q <= 1'b0;
      ar_bus_q <= '0;
      rr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rst_q <= 1'b0;
      if (ar_load) begin
        ar_vld_q <= 1'b1;
        ar_bus_q <= cand_bus;
        rr_ptr_q <= win_idx + CH_W'(1);
      end else if (ebiu_ebiuif_ar_grant) begin
        ar_vld_q <= 1'b0;
      end
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Order FIFO storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge forever_cpuclk) begin
    if (push & ~cpurst) fifo_q[wr_ptr_q] <= ac_tgt;
  end

endmodule

// File: tb/tb_ct_ciu_ebiuif_mc.sv
module tb_ct_ciu_ebiuif_mc;
  localparam int N  = 2;
  localparam int AW = 69;
  localparam int PA = 40;
  localparam int D  = 4;

  logic            forever_cpuclk;
  logic            cpurst;
  logic [N-1:0]    snbx_ebiuif_arvalid;
  logic [N*AW-1:0] snbx_ebiuif_arbus;
  logic [N-1:0]    ebiuif_snbx_ar_grant;
  logic            vb_ebiuif_addr_depd;
  logic [7:0]      ebiuif_vb_index;
  logic            ebiuif_ebiu_arvalid;
  logic [AW-1:0]   ebiuif_ebiu_arbus;
  logic            ebiu_ebiuif_ar_grant;
  logic            ebiu_ebiuif_rvalid;
  logic [5:0]      ebiu_ebiuif_rid;
  logic [127:0]    ebiu_ebiuif_rdata;
  logic [3:0]      ebiu_ebiuif_rresp;
  logic            ebiu_ebiuif_rlast;
  logic [N-1:0]    ebiuif_snbx_rvalid;
  logic [127:0]    ebiuif_xx_rdata;
  logic [3:0]      ebiuif_xx_rresp;
  logic            ebiuif_xx_rlast;
  logic            ebiuif_ebiu_r_grant;
  logic            ebiu_ebiuif_acvalid;
  logic [PA-1:0]   ebiu_ebiuif_acaddr;
  logic [3:0]      ebiu_ebiuif_acsnoop;
  logic [4:0]      ebiu_ebiuif_acid;
  logic [2:0]      ebiu_ebiuif_acprot;
  logic [N-1:0]    ebiuif_snbx_acvalid;
  logic            ebiuif_ctcq_acvalid;
  logic [PA-1:0]   ebiuif_xx_acaddr;
  logic [3:0]      ebiuif_xx_acsnoop;
  logic [4:0]      ebiuif_xx_acid;
  logic [2:0]      ebiuif_xx_acprot;
  logic [N-1:0]    snbx_ebiuif_ac_grant;
  logic            ctcq_ebiuif_ac_grant;
  logic            ebiuif_ebiu_ac_grant;
  logic [N-1:0]    snbx_ebiuif_crvalid;
  logic [N*5-1:0]  snbx_ebiuif_crresp;
  logic            ctcq_ebiuif_crvalid;
  logic [4:0]      ctcq_ebiuif_crresp;
  logic [N-1:0]    ebiuif_snbx_cr_grant;
  logic            ebiuif_ctcq_cr_grant;
  logic            ebiuif_ebiu_crvalid;
  logic [4:0]      ebiuif_ebiu_crresp;
  logic            ebiu_ebiuif_cr_grant;

  int checks = 0;
  int errors = 0;

  ct_ciu_ebiuif_mc #(
    .SNOOP_NUM(N), .ARWIDTH(AW), .PA_WIDTH(PA), .CR_DEPTH(D)
  ) dut (
    .forever_cpuclk(forever_cpuclk), .cpurst(cpurst),
    .snbx_ebiuif_arvalid(snbx_ebiuif_arvalid), .snbx_ebiuif_arbus(snbx_ebiuif_arbus),
    .ebiuif_snbx_ar_grant(ebiuif_snbx_ar_grant), .vb_ebiuif_addr_depd(vb_ebiuif_addr_depd),
    .ebiuif_vb_index(ebiuif_vb_index), .ebiuif_ebiu_arvalid(ebiuif_ebiu_arvalid),
    .ebiuif_ebiu_arbus(ebiuif_ebiu_arbus), .ebiu_ebiuif_ar_grant(ebiu_ebiuif_ar_grant),
    .ebiu_ebiuif_rvalid(ebiu_ebiuif_rvalid), .ebiu_ebiuif_rid(ebiu_ebiuif_rid),
    .ebiu_ebiuif_rdata(ebiu_ebiuif_rdata), .ebiu_ebiuif_rresp(ebiu_ebiuif_rresp),
    .ebiu_ebiuif_rlast(ebiu_ebiuif_rlast), .ebiuif_snbx_rvalid(ebiuif_snbx_rvalid),
    .ebiuif_xx_rdata(ebiuif_xx_rdata), .ebiuif_xx_rresp(ebiuif_xx_rresp),
    .ebiuif_xx_rlast(ebiuif_xx_rlast), .ebiuif_ebiu_r_grant(ebiuif_ebiu_r_grant),
    .ebiu_ebiuif_acvalid(ebiu_ebiuif_acvalid), .ebiu_ebiuif_acaddr(ebiu_ebiuif_acaddr),
    .ebiu_ebiuif_acsnoop(ebiu_ebiuif_acsnoop), .ebiu_ebiuif_acid(ebiu_ebiuif_acid),
    .ebiu_ebiuif_acprot(ebiu_ebiuif_acprot), .ebiuif_snbx_acvalid(ebiuif_snbx_acvalid),
    .ebiuif_ctcq_acvalid(ebiuif_ctcq_acvalid), .ebiuif_xx_acaddr(ebiuif_xx_acaddr),
    .ebiuif_xx_acsnoop(ebiuif_xx_acsnoop), .ebiuif_xx_acid(ebiuif_xx_acid),
    .ebiuif_xx_acprot(ebiuif_xx_acprot), .snbx_ebiuif_ac_grant(snbx_ebiuif_ac_grant),
    .ctcq_ebiuif_ac_grant(ctcq_ebiuif_ac_grant), .ebiuif_ebiu_ac_grant(ebiuif_ebiu_ac_grant),
    .snbx_ebiuif_crvalid(snbx_ebiuif_crvalid), .snbx_ebiuif_crresp(snbx_ebiuif_crresp),
    .ctcq_ebiuif_crvalid(ctcq_ebiuif_crvalid), .ctcq_ebiuif_crresp(ctcq_ebiuif_crresp),
    .ebiuif_snbx_cr_grant(ebiuif_snbx_cr_grant), .ebiuif_ctcq_cr_grant(ebiuif_ctcq_cr_grant),
    .ebiuif_ebiu_crvalid(ebiuif_ebiu_crvalid), .ebiuif_ebiu_crresp(ebiuif_ebiu_crresp),
    .ebiu_ebiuif_cr_grant(ebiu_ebiuif_cr_grant)
  );

  initial forever_cpuclk = 1'b0;
  always #5 forever_cpuclk = ~forever_cpuclk;

  // Reference model: transaction-level view of the block.
  int            m_ptr;
  bit            m_vld;
  logic [AW-1:0] m_bus;
  int            m_q[$];   // outstanding snoop targets in acceptance order
  bit            m_gate;   // previous edge was a reset edge

  int            e_win, e_tgt;
  bit            e_load, e_pop;
  logic [N-1:0]  e_ar_grant, e_rvalid, e_snb_ac, e_snb_crg;
  logic [7:0]    e_vb;
  logic          e_arvalid, e_r_grant, e_ctcq_ac, e_ac_grant, e_ctcq_crg, e_crvalid;
  logic [4:0]    e_crresp;

  task automatic model_eval();
    bit blk, full, dvm, ok;
    blk   = m_gate || cpurst;
    e_win = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (e_win < 0 && snbx_ebiuif_arvalid[idx]) e_win = idx;
    end
    e_vb = 8'h0;
    if (e_win >= 0) e_vb = snbx_ebiuif_arbus[e_win*AW+6 +: 8];
    e_load = !blk && e_win >= 0 && !vb_ebiuif_addr_depd && (!m_vld || ebiu_ebiuif_ar_grant);
    e_ar_grant = '0;
    if (e_load) e_ar_grant[e_win] = 1'b1;
    e_arvalid = m_vld && !blk;
    e_rvalid  = '0;
    if (ebiu_ebiuif_rvalid && !blk) e_rvalid[ebiu_ebiuif_rid % N] = 1'b1;
    e_r_grant = ebiu_ebiuif_rvalid && !blk;
    full  = (m_q.size() == D);
    dvm   = (ebiu_ebiuif_acsnoop >= 4'd14);
    e_tgt = dvm ? N : int'((ebiu_ebiuif_acaddr >> 6) % N);
    ok    = ebiu_ebiuif_acvalid && !full && !blk;
    e_snb_ac = '0;
    if (ok && !dvm) e_snb_ac[e_tgt] = 1'b1;
    e_ctcq_ac  = ok && dvm;
    e_ac_grant = ok && (dvm ? ctcq_ebiuif_ac_grant : snbx_ebiuif_ac_grant[e_tgt]);
    e_crvalid  = 1'b0;
    e_crresp   = 5'd0;
    e_snb_crg  = '0;
    e_ctcq_crg = 1'b0;
    if (m_q.size() > 0 && !blk) begin
      if (m_q[0] == N) begin
        e_crvalid  = ctcq_ebiuif_crvalid;
        e_crresp   = ctcq_ebiuif_crresp;
        e_ctcq_crg = ebiu_ebiuif_cr_grant;
      end else begin
        e_crvalid          = snbx_ebiuif_crvalid[m_q[0]];
        e_crresp           = snbx_ebiuif_crresp[m_q[0]*5 +: 5];
        e_snb_crg[m_q[0]]  = ebiu_ebiuif_cr_grant;
      end
    end
    e_pop = ebiu_ebiuif_cr_grant && e_crvalid;
  endtask

  task automatic step();
    model_eval();
    if (cpurst) begin
      m_ptr = 0; m_vld = 0; m_bus = '0; m_q.delete(); m_gate = 1;
    end else begin
      m_gate = 0;
      if (e_load) begin
        m_vld = 1;
        m_bus = snbx_ebiuif_arbus[e_win*AW +: AW];
        m_ptr = (e_win + 1) % N;
      end else if (ebiu_ebiuif_ar_grant) begin
        m_vld = 0;
      end
      if (e_pop) void'(m_q.pop_front());
      if (e_ac_grant) m_q.push_back(e_tgt);
    end
    @(posedge forever_cpuclk);
    #1;
  endtask

  task automatic idle();
    snbx_ebiuif_arvalid = '0;  snbx_ebiuif_arbus = '0;   vb_ebiuif_addr_depd = 0;
    ebiu_ebiuif_ar_grant = 0;  ebiu_ebiuif_rvalid = 0;   ebiu_ebiuif_rid = '0;
    ebiu_ebiuif_rdata = '0;    ebiu_ebiuif_rresp = '0;   ebiu_ebiuif_rlast = 0;
    ebiu_ebiuif_acvalid = 0;   ebiu_ebiuif_acaddr = '0;  ebiu_ebiuif_acsnoop = '0;
    ebiu_ebiuif_acid = '0;     ebiu_ebiuif_acprot = '0;  snbx_ebiuif_ac_grant = '0;
    ctcq_ebiuif_ac_grant = 0;  snbx_ebiuif_crvalid = '0; snbx_ebiuif_crresp = '0;
    ctcq_ebiuif_crvalid = 0;   ctcq_ebiuif_crresp = '0;  ebiu_ebiuif_cr_grant = 0;
  endtask

  task automatic do_reset();
    idle();
    cpurst = 1'b1;
    step();
    cpurst = 1'b0;
    step();
  endtask

  function automatic logic [AW-1:0] rand_bus();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[AW-1:0];
  endfunction

  task automatic test_reset();
    logic [9:0] outs;
    cpurst = 1'b1;
    snbx_ebiuif_arvalid = '1; ebiu_ebiuif_rvalid = 1; ebiu_ebiuif_acvalid = 1;
    snbx_ebiuif_ac_grant = '1; ctcq_ebiuif_ac_grant = 1; ebiu_ebiuif_ar_grant = 1;
    step();
    #1;
    outs = {ebiuif_snbx_ar_grant, ebiuif_ebiu_arvalid, ebiuif_snbx_rvalid, ebiuif_ebiu_r_grant,
            ebiuif_snbx_acvalid, ebiuif_ctcq_acvalid, ebiuif_ebiu_ac_grant};
    checks++;
    if (outs !== 10'd0) begin errors++; $display("FAIL in_reset got %b want 0", outs); end
    step();
    cpurst = 1'b0;
    #1;
    outs = {ebiuif_snbx_ar_grant, ebiuif_ebiu_arvalid, ebiuif_snbx_rvalid, ebiuif_ebiu_r_grant,
            ebiuif_snbx_acvalid, ebiuif_ctcq_acvalid, ebiuif_ebiu_ac_grant};
    checks++;
    if (outs !== 10'd0) begin errors++; $display("FAIL first_after_reset got %b want 0", outs); end
    checks++;
    if ({ebiuif_ebiu_arbus, ebiuif_ebiu_crvalid} !== '0) begin
      errors++; $display("FAIL reset_arbus_cr got %h want 0", ebiuif_ebiu_arbus);
    end
    step();
    #1;
    checks++;
    if ({ebiuif_snbx_ar_grant, ebiuif_ebiu_ac_grant, ebiuif_ebiu_r_grant} !== 4'b0111) begin
      errors++;
      $display("FAIL rr_start got %b want 0111",
               {ebiuif_snbx_ar_grant, ebiuif_ebiu_ac_grant, ebiuif_ebiu_r_grant});
    end
    step();
    idle();
  endtask

  task automatic test_ar_rr();
    logic [AW-1:0] b [N];
    logic [N-1:0]  want;
    do_reset();
    b[0] = rand_bus(); b[1] = rand_bus();
    snbx_ebiuif_arbus = {b[1], b[0]};
    snbx_ebiuif_arvalid = 2'b11;
    ebiu_ebiuif_ar_grant = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      want = (c % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (ebiuif_snbx_ar_grant !== want) begin
        errors++; $display("FAIL rr_grant c%0d got %b want %b", c, ebiuif_snbx_ar_grant, want);
      end
      checks++;
      if (ebiuif_ebiu_arvalid !== (c >= 1)) begin
        errors++; $display("FAIL rr_arvalid c%0d got %b want %b", c, ebiuif_ebiu_arvalid, c >= 1);
      end
      if (c >= 1) begin
        checks++;
        if (ebiuif_ebiu_arbus !== b[(c - 1) % 2]) begin
          errors++;
          $display("FAIL rr_arbus c%0d got %h want %h", c, ebiuif_ebiu_arbus, b[(c - 1) % 2]);
        end
      end
      step();
    end
    idle();
  endtask

  task automatic test_ar_depd_hold();
    logic [AW-1:0] b1;
    do_reset();
    b1 = rand_bus();
    snbx_ebiuif_arbus = {b1, rand_bus()};
    snbx_ebiuif_arvalid = 2'b10;
    vb_ebiuif_addr_depd = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) vb_ebiuif_addr_depd = 1'b0;
      #1;
      checks++;
      if (ebiuif_snbx_ar_grant !== ((c == 3) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL depd_grant c%0d got %b", c, ebiuif_snbx_ar_grant);
      end
      checks++;
      if (ebiuif_vb_index !== b1[13:6] || ebiuif_ebiu_arvalid !== 1'b0) begin
        errors++;
        $display("FAIL depd_index c%0d got %h/%b want %h/0", c, ebiuif_vb_index,
                 ebiuif_ebiu_arvalid, b1[13:6]);
      end
      step();
    end
    // Registered request held while ebiu withholds its grant and depd toggles.
    snbx_ebiuif_arvalid = 2'b01;
    snbx_ebiuif_arbus[AW-1:0] = rand_bus();
    for (int c = 0; c < 5; c++) begin
      vb_ebiuif_addr_depd = c[0];
      #1;
      checks++;
      if (ebiuif_ebiu_arvalid !== 1'b1 || ebiuif_ebiu_arbus !== b1 ||
          ebiuif_snbx_ar_grant !== 2'b00) begin
        errors++;
        $display("FAIL ar_hold c%0d got %b/%h/%b want 1/%h/00", c, ebiuif_ebiu_arvalid,
                 ebiuif_ebiu_arbus, ebiuif_snbx_ar_grant, b1);
      end
      step();
    end
    ebiu_ebiuif_ar_grant = 1'b1;
    vb_ebiuif_addr_depd = 1'b1;
    #1;
    checks++;
    if (ebiuif_snbx_ar_grant !== 2'b00) begin
      errors++; $display("FAIL depd_blocks_reload got %b want 00", ebiuif_snbx_ar_grant);
    end
    step();
    ebiu_ebiuif_ar_grant = 1'b0;
    #1;
    checks++;
    if (ebiuif_ebiu_arvalid !== 1'b0) begin
      errors++; $display("FAIL ar_released got %b want 0", ebiuif_ebiu_arvalid);
    end
    step();
    idle();
  endtask

  task automatic test_r_path();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      ebiu_ebiuif_rvalid = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ebiu_ebiuif_rid    = (c == 0) ? 6'h01 : 6'($urandom);
      ebiu_ebiuif_rdata  = {$urandom, $urandom, $urandom, $urandom};
      ebiu_ebiuif_rresp  = 4'($urandom);
      ebiu_ebiuif_rlast  = 1'($urandom);
      #1;
      model_eval();
      if (c == 0) begin
        checks++;
        if ({ebiuif_snbx_rvalid, ebiuif_ebiu_r_grant} !== 3'b101) begin
          errors++;
          $display("FAIL r_rid1 got %b want 101", {ebiuif_snbx_rvalid, ebiuif_ebiu_r_grant});
        end
      end
      checks++;
      if ({ebiuif_snbx_rvalid, ebiuif_ebiu_r_grant} !== {e_rvalid, e_r_grant} ||
          {ebiuif_xx_rdata, ebiuif_xx_rresp, ebiuif_xx_rlast} !==
          {ebiu_ebiuif_rdata, ebiu_ebiuif_rresp, ebiu_ebiuif_rlast}) begin
        errors++;
        $display("FAIL r_route c%0d got %b/%b/%h want %b/%b/%h", c, ebiuif_snbx_rvalid,
                 ebiuif_ebiu_r_grant, ebiuif_xx_rdata, e_rvalid, e_r_grant, ebiu_ebiuif_rdata);
      end
      step();
    end
    idle();
  endtask

  task automatic test_ac_cr_order();
    logic [4:0] r0, r1, rc;
    do_reset();
    ebiu_ebiuif_acvalid = 1'b1;
    // snb1 target; ctcq grant from a non-target must be ignored.
    ebiu_ebiuif_acaddr = 40'h12_3456_7840; ebiu_ebiuif_acsnoop = 4'd3;
    snbx_ebiuif_ac_grant = 2'b01; ctcq_ebiuif_ac_grant = 1'b1;
    #1;
    checks++;
    if ({ebiuif_snbx_acvalid, ebiuif_ctcq_acvalid, ebiuif_ebiu_ac_grant} !== 4'b1000) begin
      errors++;
      $display("FAIL ac_nontarget got %b want 1000",
               {ebiuif_snbx_acvalid, ebiuif_ctcq_acvalid, ebiuif_ebiu_ac_grant});
    end
    step();
    snbx_ebiuif_ac_grant = 2'b10; ctcq_ebiuif_ac_grant = 1'b0;
    #1;
    checks++;
    if ({ebiuif_snbx_acvalid, ebiuif_ctcq_acvalid, ebiuif_ebiu_ac_grant} !== 4'b1001) begin
      errors++; $display("FAIL ac_snb1 got %b want 1001",
                         {ebiuif_snbx_acvalid, ebiuif_ctcq_acvalid, ebiuif_ebiu_ac_grant});
    end
    step();
    ebiu_ebiuif_acsnoop = 4'b1111; ebiu_ebiuif_acaddr = 40'h0;
    snbx_ebiuif_ac_grant = 2'b00; ctcq_ebiuif_ac_grant = 1'b1;
    #1;
    checks++;
    if ({ebiuif_snbx_acvalid, ebiuif_ctcq_acvalid, ebiuif_ebiu_ac_grant} !== 4'b0011) begin
      errors++; $display("FAIL ac_dvm got %b want 0011",
                         {ebiuif_snbx_acvalid, ebiuif_ctcq_acvalid, ebiuif_ebiu_ac_grant});
    end
    step();
    ebiu_ebiuif_acsnoop = 4'd7; ebiu_ebiuif_acaddr = 40'hff_ffff_ffbf;
    snbx_ebiuif_ac_grant = 2'b01; ctcq_ebiuif_ac_grant = 1'b0;
    #1;
    checks++;
    if ({ebiuif_snbx_acvalid, ebiuif_ctcq_acvalid, ebiuif_ebiu_ac_grant} !== 4'b0101) begin
      errors++; $display("FAIL ac_snb0 got %b want 0101",
                         {ebiuif_snbx_acvalid, ebiuif_ctcq_acvalid, ebiuif_ebiu_ac_grant});
    end
    step();
    idle();
    r0 = 5'h0a; r1 = 5'h15; rc = 5'h1f;
    snbx_ebiuif_crvalid = 2'b11; snbx_ebiuif_crresp = {r1, r0};
    ctcq_ebiuif_crvalid = 1'b1;  ctcq_ebiuif_crresp = rc;
    #1;
    checks++;
    if ({ebiuif_ebiu_crvalid, ebiuif_ebiu_crresp, ebiuif_snbx_cr_grant} !== {1'b1, r1, 2'b00}) begin
      errors++; $display("FAIL cr_wait got %b/%h/%b want 1/%h/00", ebiuif_ebiu_crvalid,
                         ebiuif_ebiu_crresp, ebiuif_snbx_cr_grant, r1);
    end
    step();
    ebiu_ebiuif_cr_grant = 1'b1;
    for (int c = 0; c < 4; c++) begin
      logic [8:0] want;
      case (c)
        0:       want = {1'b1, r1, 2'b10, 1'b0};
        1:       want = {1'b1, rc, 2'b00, 1'b1};
        2:       want = {1'b1, r0, 2'b01, 1'b0};
        default: want = 9'd0;
      endcase
      #1;
      checks++;
      if ({ebiuif_ebiu_crvalid, ebiuif_ebiu_crresp, ebiuif_snbx_cr_grant,
           ebiuif_ctcq_cr_grant} !== want) begin
        errors++;
        $display("FAIL cr_order c%0d got %b want %b", c, {ebiuif_ebiu_crvalid,
                 ebiuif_ebiu_crresp, ebiuif_snbx_cr_grant, ebiuif_ctcq_cr_grant}, want);
      end
      step();
    end
    idle();
  endtask

  task automatic test_fifo_full();
    do_reset();
    ebiu_ebiuif_acvalid = 1'b1; ebiu_ebiuif_acaddr = 40'h100; ebiu_ebiuif_acsnoop = 4'd1;
    snbx_ebiuif_ac_grant = 2'b01;
    for (int c = 0; c < D; c++) begin
      #1;
      checks++;
      if (ebiuif_ebiu_ac_grant !== 1'b1) begin
        errors++; $display("FAIL fill c%0d got %b want 1", c, ebiuif_ebiu_ac_grant);
      end
      step();
    end
    // Full: a CR pop in the same cycle must not unblock the snoop.
    snbx_ebiuif_crvalid = 2'b01; snbx_ebiuif_crresp = 10'h003; ebiu_ebiuif_cr_grant = 1'b1;
    #1;
    checks++;
    if ({ebiuif_snbx_acvalid, ebiuif_ctcq_acvalid, ebiuif_ebiu_ac_grant,
         ebiuif_snbx_cr_grant, ebiuif_ebiu_crvalid} !== 7'b0000011) begin
      errors++; $display("FAIL full_block got %b want 0000011", {ebiuif_snbx_acvalid,
        ebiuif_ctcq_acvalid, ebiuif_ebiu_ac_grant, ebiuif_snbx_cr_grant, ebiuif_ebiu_crvalid});
    end
    step();
    snbx_ebiuif_crvalid = 2'b00; ebiu_ebiuif_cr_grant = 1'b0;
    #1;
    checks++;
    if ({ebiuif_snbx_acvalid, ebiuif_ebiu_ac_grant} !== 3'b011) begin
      errors++; $display("FAIL after_pop got %b want 011",
                         {ebiuif_snbx_acvalid, ebiuif_ebiu_ac_grant});
    end
    step();
    idle();
    snbx_ebiuif_crvalid = 2'b01; ebiu_ebiuif_cr_grant = 1'b1;
    for (int c = 0; c < D; c++) step();
    #1;
    checks++;
    if (ebiuif_ebiu_crvalid !== 1'b0) begin
      errors++; $display("FAIL drained got %b want 0", ebiuif_ebiu_crvalid);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    snbx_ebiuif_arvalid = 2'b01; snbx_ebiuif_arbus = {rand_bus(), rand_bus()};
    ebiu_ebiuif_acvalid = 1'b1; snbx_ebiuif_ac_grant = 2'b01;
    step();
    idle();
    #1;
    checks++;
    if (ebiuif_ebiu_arvalid !== 1'b1) begin
      errors++; $display("FAIL mid_loaded got %b want 1", ebiuif_ebiu_arvalid);
    end
    cpurst = 1'b1;
    snbx_ebiuif_arvalid = 2'b11; ebiu_ebiuif_ar_grant = 1'b1;
    snbx_ebiuif_crvalid = 2'b11; ebiu_ebiuif_cr_grant = 1'b1;
    #1;
    checks++;
    if ({ebiuif_snbx_ar_grant, ebiuif_ebiu_arvalid, ebiuif_snbx_cr_grant,
         ebiuif_ebiu_crvalid} !== 6'd0) begin
      errors++; $display("FAIL mid_reset got %b want 0", {ebiuif_snbx_ar_grant,
        ebiuif_ebiu_arvalid, ebiuif_snbx_cr_grant, ebiuif_ebiu_crvalid});
    end
    step();
    cpurst = 1'b0;
    #1;
    checks++;
    if ({ebiuif_ebiu_arvalid, ebiuif_snbx_ar_grant, ebiuif_snbx_cr_grant} !== 5'd0) begin
      errors++; $display("FAIL mid_after got %b want 0",
                         {ebiuif_ebiu_arvalid, ebiuif_snbx_ar_grant, ebiuif_snbx_cr_grant});
    end
    step();
    #1;
    checks++;
    if (ebiuif_ebiu_crvalid !== 1'b0) begin
      errors++; $display("FAIL mid_fifo_flushed got %b want 0", ebiuif_ebiu_crvalid);
    end
    step();
    idle();
  endtask

  task automatic test_random();
    logic [63:0] a;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      cpurst = ($urandom_range(0, 99) == 0);
      snbx_ebiuif_arvalid  = N'($urandom);
      snbx_ebiuif_arbus    = {rand_bus(), rand_bus()};
      vb_ebiuif_addr_depd  = ($urandom_range(0, 3) == 0);
      ebiu_ebiuif_ar_grant = 1'($urandom);
      ebiu_ebiuif_rvalid   = 1'($urandom);
      ebiu_ebiuif_rid      = 6'($urandom);
      ebiu_ebiuif_rdata    = {$urandom, $urandom, $urandom, $urandom};
      ebiu_ebiuif_rresp    = 4'($urandom);
      ebiu_ebiuif_rlast    = 1'($urandom);
      a = {$urandom, $urandom};
      ebiu_ebiuif_acvalid  = ($urandom_range(0, 9) < 6);
      ebiu_ebiuif_acaddr   = a[PA-1:0];
      ebiu_ebiuif_acsnoop  = 4'($urandom);
      ebiu_ebiuif_acid     = 5'($urandom);
      ebiu_ebiuif_acprot   = 3'($urandom);
      snbx_ebiuif_ac_grant = N'($urandom);
      ctcq_ebiuif_ac_grant = 1'($urandom);
      snbx_ebiuif_crvalid  = N'($urandom);
      snbx_ebiuif_crresp   = (N*5)'($urandom);
      ctcq_ebiuif_crvalid  = 1'($urandom);
      ctcq_ebiuif_crresp   = 5'($urandom);
      ebiu_ebiuif_cr_grant = ($urandom_range(0, 9) < 6);
      #1;
      model_eval();
      checks++;
      if ({ebiuif_snbx_ar_grant, ebiuif_ebiu_arvalid, ebiuif_vb_index} !==
          {e_ar_grant, e_arvalid, e_vb} || ebiuif_ebiu_arbus !== m_bus) begin
        errors++;
        $display("FAIL rnd_ar c%0d got %b/%b/%h/%h want %b/%b/%h/%h", c, ebiuif_snbx_ar_grant,
                 ebiuif_ebiu_arvalid, ebiuif_vb_index, ebiuif_ebiu_arbus, e_ar_grant, e_arvalid,
                 e_vb, m_bus);
      end
      checks++;
      if ({ebiuif_snbx_rvalid, ebiuif_ebiu_r_grant} !== {e_rvalid, e_r_grant}) begin
        errors++; $display("FAIL rnd_r c%0d got %b/%b want %b/%b", c, ebiuif_snbx_rvalid,
                           ebiuif_ebiu_r_grant, e_rvalid, e_r_grant);
      end
      checks++;
      if ({ebiuif_snbx_acvalid, ebiuif_ctcq_acvalid, ebiuif_ebiu_ac_grant} !==
          {e_snb_ac, e_ctcq_ac, e_ac_grant} ||
          {ebiuif_xx_acaddr, ebiuif_xx_acsnoop, ebiuif_xx_acid, ebiuif_xx_acprot} !==
          {ebiu_ebiuif_acaddr, ebiu_ebiuif_acsnoop, ebiu_ebiuif_acid, ebiu_ebiuif_acprot}) begin
        errors++; $display("FAIL rnd_ac c%0d got %b/%b/%b want %b/%b/%b", c,
                           ebiuif_snbx_acvalid, ebiuif_ctcq_acvalid, ebiuif_ebiu_ac_grant,
                           e_snb_ac, e_ctcq_ac, e_ac_grant);
      end
      checks++;
      if ({ebiuif_ebiu_crvalid, ebiuif_ebiu_crresp, ebiuif_snbx_cr_grant,
           ebiuif_ctcq_cr_grant} !== {e_crvalid, e_crresp, e_snb_crg, e_ctcq_crg}) begin
        errors++; $display("FAIL rnd_cr c%0d got %b/%h/%b/%b want %b/%h/%b/%b", c,
                           ebiuif_ebiu_crvalid, ebiuif_ebiu_crresp, ebiuif_snbx_cr_grant,
                           ebiuif_ctcq_cr_grant, e_crvalid, e_crresp, e_snb_crg, e_ctcq_crg);
      end
      step();
    end
    cpurst = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    cpurst = 1'b1;
    m_ptr = 0; m_vld = 0; m_bus = '0; m_gate = 1;
    test_reset();
    test_ar_rr();
    test_ar_depd_hold();
    test_r_path();
    test_ac_cr_order();
    test_fifo_full();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
